// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the controller state encoding and the index-width helper.
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch and program-load bus of the instruction memory.
// The master drives fetch requests and the load stream; the slave is the memory.
interface imem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);

   logic [ADDR_W-1:0] pc;
   logic              fetch_en;
   logic [DATA_W-1:0] instruction;
   logic              instr_valid;
   logic              misaligned;
   logic              out_of_range;
   logic              busy;

   logic              prog_start;
   logic [ADDR_W-1:0] prog_base;
   logic              prog_valid;
   logic              prog_last;
   logic [DATA_W-1:0] prog_data;
   logic              prog_ready;
   logic              prog_done;
   logic              prog_err;

   modport master (
      output pc, fetch_en, prog_start, prog_base, prog_valid, prog_last, prog_data,
      input  instruction, instr_valid, misaligned, out_of_range, busy,
             prog_ready, prog_done, prog_err
   );

   modport slave (
      input  pc, fetch_en, prog_start, prog_base, prog_valid, prog_last, prog_data,
      output instruction, instr_valid, misaligned, out_of_range, busy,
             prog_ready, prog_done, prog_err
   );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Left without reset so it maps onto distributed RAM.
module imem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_prog.sv
// Loadable instruction memory: clears itself after reset, accepts a valid/ready
// program stream, and serves fetches with optional one-cycle latency and fault flags.
module imem_prog
   import imem_pkg::*;
#(
   parameter int              DATA_W   = 32,
   parameter int              DEPTH    = 64,
   parameter int              ADDR_W   = 32,
   parameter int              READ_LAT = 0,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
   input logic   clk,
   input logic   rst_n,
   imem_if.slave bus
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  clr_ptr, load_ptr;
   logic              done_q, err_q;
   logic              accept, overrun;
   logic              busy, ready;
   logic              we;
   logic [IDX_W-1:0]  waddr;
   logic [DATA_W-1:0] wdata;
   logic [IDX_W-1:0]  fetch_idx;
   logic [DATA_W-1:0] rdata;
   logic              pc_mis, pc_oor;
   logic [DATA_W-1:0] f_instr;
   logic              f_vld, f_mis, f_oor;
   logic              unused_ok;

   assign accept  = (state == LOAD) && bus.prog_valid;
   // The last slot without prog_last ends the load; there is no wrap to index 0.
   assign overrun = accept && !bus.prog_last && (load_ptr == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CLEAR;
         clr_ptr  <= '0;
         load_ptr <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= accept && bus.prog_last;
         err_q  <= overrun;
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
         end
         if ((state == IDLE) && bus.prog_start) begin
            load_ptr <= bus.prog_base[IDX_W+1:2];
         end else if (accept) begin
            load_ptr <= load_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         CLEAR: if (clr_ptr == LAST_IDX) state_nxt = IDLE;
         IDLE:  if (bus.prog_start) state_nxt = LOAD;
         LOAD:  if (accept && (bus.prog_last || (load_ptr == LAST_IDX))) state_nxt = IDLE;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      ready = 1'b0;
      we    = 1'b0;
      waddr = clr_ptr;
      wdata = NOP_WORD;
      unique case (state)
         CLEAR: begin
            busy = 1'b1;
            we   = 1'b1;
         end
         LOAD: begin
            busy  = 1'b1;
            ready = 1'b1;
            we    = accept;
            waddr = load_ptr;
            wdata = bus.prog_data;
         end
         default: ;
      endcase
   end

   assign bus.busy       = busy;
   assign bus.prog_ready = ready;
   assign bus.prog_done  = done_q;
   assign bus.prog_err   = err_q;

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (fetch_idx),
      .rdata (rdata)
   );

   assign fetch_idx = bus.pc[IDX_W+1:2];
   assign pc_mis    = (bus.pc[1:0] != 2'b00);
   assign pc_oor    = ((bus.pc >> (IDX_W + 2)) != '0);

   always_comb begin
      f_instr = NOP_WORD;
      f_vld   = 1'b0;
      f_mis   = 1'b0;
      f_oor   = 1'b0;
      if (!busy) begin
         if (pc_mis) begin
            f_mis = 1'b1;
         end else if (pc_oor) begin
            f_oor = 1'b1;
         end else begin
            f_instr = rdata;
            f_vld   = 1'b1;
         end
      end
   end

   if (READ_LAT == 0) begin : g_comb
      assign bus.instruction  = f_instr;
      assign bus.instr_valid  = f_vld;
      assign bus.misaligned   = f_mis;
      assign bus.out_of_range = f_oor;
   end else begin : g_reg
      logic [DATA_W-1:0] instr_p1;
      logic              vld_p1, mis_p1, oor_p1;

      // Fetch stage boundary: capture only on requested cycles, hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            instr_p1 <= NOP_WORD;
            vld_p1   <= 1'b0;
            mis_p1   <= 1'b0;
            oor_p1   <= 1'b0;
         end else if (bus.fetch_en) begin
            instr_p1 <= f_instr;
            vld_p1   <= f_vld;
            mis_p1   <= f_mis;
            oor_p1   <= f_oor;
         end
      end

      assign bus.instruction  = busy ? NOP_WORD : instr_p1;
      assign bus.instr_valid  = !busy && vld_p1;
      assign bus.misaligned   = !busy && mis_p1;
      assign bus.out_of_range = !busy && oor_p1;
   end

   assign unused_ok = ^{bus.prog_base, bus.fetch_en};

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: one combinational-fetch and one registered-fetch
// instance share the same stimulus.
module tb_imem_prog;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 64;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] pc;
   logic        fetch_en;
   logic        prog_start;
   logic [31:0] prog_base;
   logic        prog_valid;
   logic        prog_last;
   logic [31:0] prog_data;

   int tests = 0;
   int fails = 0;

   imem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if0 ();
   imem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if1 ();

   assign if0.pc = pc;           assign if1.pc = pc;
   assign if0.fetch_en = fetch_en;     assign if1.fetch_en = fetch_en;
   assign if0.prog_start = prog_start; assign if1.prog_start = prog_start;
   assign if0.prog_base = prog_base;   assign if1.prog_base = prog_base;
   assign if0.prog_valid = prog_valid; assign if1.prog_valid = prog_valid;
   assign if0.prog_last = prog_last;   assign if1.prog_last = prog_last;
   assign if0.prog_data = prog_data;   assign if1.prog_data = prog_data;

   imem_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(0), .NOP_WORD(NOP))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   imem_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(1), .NOP_WORD(NOP))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc = '0; fetch_en = 1'b0; prog_start = 1'b0; prog_base = '0;
      prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
   endtask

   task automatic test_reset();
      int n;
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      tests++; if (if0.busy !== 1'b1 || if1.busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b/%b want 1", if0.busy, if1.busy); end
      tests++; if (if0.instruction !== NOP || if1.instruction !== NOP) begin fails++; $display("FAIL reset_instr: got %h/%h want %h", if0.instruction, if1.instruction, NOP); end
      tests++; if ({if0.instr_valid, if0.misaligned, if0.out_of_range, if1.instr_valid, if1.misaligned, if1.out_of_range} !== 6'b0) begin fails++; $display("FAIL reset_fetch_flags: got %b%b%b/%b%b%b want 0", if0.instr_valid, if0.misaligned, if0.out_of_range, if1.instr_valid, if1.misaligned, if1.out_of_range); end
      tests++; if ({if0.prog_ready, if0.prog_done, if0.prog_err} !== 3'b0) begin fails++; $display("FAIL reset_prog_flags: got %b%b%b want 000", if0.prog_ready, if0.prog_done, if0.prog_err); end
      rst_n = 1'b1;
      n = 0;
      while (if0.busy && n < 200) begin tick(); n++; end
      tests++; if (n !== 64) begin fails++; $display("FAIL clear_cycles: got %0d want 64", n); end
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL clear_done_lat1: busy got %b want 0", if1.busy); end
      for (int a = 0; a < 256; a += 4) begin
         pc = 32'(a);
         #1;
         tests++; if (if0.instruction !== 32'h0 || if0.instr_valid !== 1'b1) begin fails++; $display("FAIL cleared_word pc=%0d: got %h v=%b want 00000000 v=1", a, if0.instruction, if0.instr_valid); end
      end
      pc = 32'd0; fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      tests++; if (if1.instruction !== 32'h0 || if1.instr_valid !== 1'b1) begin fails++; $display("FAIL cleared_word_lat1: got %h v=%b want 00000000 v=1", if1.instruction, if1.instr_valid); end
   endtask

   task automatic test_load_basic();
      prog_base = 32'd0; prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      tests++; if (if0.prog_ready !== 1'b1 || if1.prog_ready !== 1'b1) begin fails++; $display("FAIL load_ready: got %b/%b want 1", if0.prog_ready, if1.prog_ready); end
      prog_valid = 1'b1; prog_data = 32'h20100015; tick();
      prog_data = 32'h20110017; tick();
      tests++; if (if0.prog_done !== 1'b0) begin fails++; $display("FAIL load_done_early: got %b want 0", if0.prog_done); end
      prog_data = 32'hAE300004; prog_last = 1'b1; tick();
      prog_valid = 1'b0; prog_last = 1'b0;
      tests++; if (if0.prog_done !== 1'b1 || if1.prog_done !== 1'b1) begin fails++; $display("FAIL load_done: got %b/%b want 1", if0.prog_done, if1.prog_done); end
      tests++; if (if0.busy !== 1'b0 || if0.prog_ready !== 1'b0 || if0.prog_err !== 1'b0) begin fails++; $display("FAIL load_to_idle: busy=%b ready=%b err=%b want 000", if0.busy, if0.prog_ready, if0.prog_err); end
      tick();
      tests++; if (if0.prog_done !== 1'b0) begin fails++; $display("FAIL load_done_pulse: got %b want 0", if0.prog_done); end
      pc = 32'd4; #1;
      tests++; if (if0.instruction !== 32'h20110017 || if0.instr_valid !== 1'b1) begin fails++; $display("FAIL fetch_pc4: got %h v=%b want 20110017 v=1", if0.instruction, if0.instr_valid); end
      fetch_en = 1'b1; #1;
      tests++; if (if1.instruction !== 32'h0) begin fails++; $display("FAIL lat1_before_edge: got %h want 00000000", if1.instruction); end
      tick();
      fetch_en = 1'b0;
      tests++; if (if1.instruction !== 32'h20110017 || if1.instr_valid !== 1'b1) begin fails++; $display("FAIL lat1_pc4: got %h v=%b want 20110017 v=1", if1.instruction, if1.instr_valid); end
      pc = 32'd8; tick();
      tests++; if (if1.instruction !== 32'h20110017) begin fails++; $display("FAIL lat1_hold: got %h want 20110017", if1.instruction); end
      tests++; if (if0.instruction !== 32'hAE300004) begin fails++; $display("FAIL fetch_pc8: got %h want ae300004", if0.instruction); end
      pc = 32'd0; #1;
      tests++; if (if0.instruction !== 32'h20100015) begin fails++; $display("FAIL fetch_pc0: got %h want 20100015", if0.instruction); end
   endtask

   task automatic test_overrun();
      prog_base = 32'd248; prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      prog_valid = 1'b1; prog_data = 32'hCAFE0001; tick();
      prog_data = 32'hCAFE0002; tick();
      tests++; if (if0.prog_err !== 1'b1 || if1.prog_err !== 1'b1) begin fails++; $display("FAIL overrun_err: got %b/%b want 1", if0.prog_err, if1.prog_err); end
      tests++; if (if0.prog_done !== 1'b0 || if0.busy !== 1'b0 || if0.prog_ready !== 1'b0) begin fails++; $display("FAIL overrun_idle: done=%b busy=%b ready=%b want 000", if0.prog_done, if0.busy, if0.prog_ready); end
      prog_data = 32'hCAFE0003; tick();
      prog_valid = 1'b0;
      tests++; if (if0.prog_err !== 1'b0) begin fails++; $display("FAIL overrun_err_pulse: got %b want 0", if0.prog_err); end
      pc = 32'd248; #1;
      tests++; if (if0.instruction !== 32'hCAFE0001) begin fails++; $display("FAIL overrun_w62: got %h want cafe0001", if0.instruction); end
      pc = 32'd252; #1;
      tests++; if (if0.instruction !== 32'hCAFE0002 || if0.instr_valid !== 1'b1) begin fails++; $display("FAIL overrun_w63: got %h v=%b want cafe0002 v=1", if0.instruction, if0.instr_valid); end
      pc = 32'd0; #1;
      tests++; if (if0.instruction !== 32'h20100015) begin fails++; $display("FAIL overrun_no_wrap: got %h want 20100015", if0.instruction); end
   endtask

   task automatic test_faults();
      pc = 32'd6; #1;
      tests++; if (if0.misaligned !== 1'b1 || if0.out_of_range !== 1'b0 || if0.instruction !== NOP || if0.instr_valid !== 1'b0) begin fails++; $display("FAIL fault_pc6: mis=%b oor=%b instr=%h v=%b want 1 0 00000000 0", if0.misaligned, if0.out_of_range, if0.instruction, if0.instr_valid); end
      pc = 32'd256; #1;
      tests++; if (if0.misaligned !== 1'b0 || if0.out_of_range !== 1'b1 || if0.instruction !== NOP || if0.instr_valid !== 1'b0) begin fails++; $display("FAIL fault_pc256: mis=%b oor=%b instr=%h v=%b want 0 1 00000000 0", if0.misaligned, if0.out_of_range, if0.instruction, if0.instr_valid); end
      pc = 32'd258; #1;
      tests++; if (if0.misaligned !== 1'b1 || if0.out_of_range !== 1'b0) begin fails++; $display("FAIL fault_precedence: mis=%b oor=%b want 1 0", if0.misaligned, if0.out_of_range); end
      pc = 32'd6; fetch_en = 1'b1; tick();
      pc = 32'd256; tick();
      tests++; if (if1.out_of_range !== 1'b1 || if1.misaligned !== 1'b0 || if1.instr_valid !== 1'b0 || if1.instruction !== NOP) begin fails++; $display("FAIL fault_lat1_pc256: mis=%b oor=%b instr=%h v=%b want 0 1 00000000 0", if1.misaligned, if1.out_of_range, if1.instruction, if1.instr_valid); end
      fetch_en = 1'b0; pc = 32'd0;
   endtask

   task automatic test_gapped();
      logic [31:0] words [3];
      words[0] = 32'h11110000; words[1] = 32'h22220000; words[2] = 32'h33330000;
      prog_base = 32'd16; prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         prog_valid = 1'b0;
         if (i == 1) begin prog_start = 1'b1; prog_base = 32'd0; end
         tick();
         prog_start = 1'b0;
         tests++; if (if0.prog_ready !== 1'b1 || if0.prog_done !== 1'b0) begin fails++; $display("FAIL gap_ready beat=%0d: ready=%b done=%b want 1 0", i, if0.prog_ready, if0.prog_done); end
         tick();
         prog_valid = 1'b1; prog_data = words[i]; prog_last = (i == 2);
         tick();
      end
      prog_valid = 1'b0; prog_last = 1'b0;
      tests++; if (if0.prog_done !== 1'b1) begin fails++; $display("FAIL gap_done: got %b want 1", if0.prog_done); end
      for (int i = 0; i < 3; i++) begin
         pc = 32'(16 + 4 * i); #1;
         tests++; if (if0.instruction !== words[i]) begin fails++; $display("FAIL gap_word%0d: got %h want %h", i, if0.instruction, words[i]); end
      end
      pc = 32'd28; #1;
      tests++; if (if0.instruction !== 32'h0) begin fails++; $display("FAIL gap_past_end: got %h want 00000000", if0.instruction); end
      pc = 32'd0; #1;
      tests++; if (if0.instruction !== 32'h20100015) begin fails++; $display("FAIL gap_restart_ignored: got %h want 20100015", if0.instruction); end
   endtask

   task automatic test_reset_abort();
      int  n;
      logic done_seen;
      prog_base = 32'd0; prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      prog_valid = 1'b1; prog_data = 32'hDEAD0000; tick();
      prog_data = 32'hDEAD0001; tick();
      prog_data = 32'hDEAD0002; prog_last = 1'b1;
      rst_n = 1'b0; #1;
      tests++; if (if0.busy !== 1'b1 || if1.busy !== 1'b1 || if0.prog_ready !== 1'b0) begin fails++; $display("FAIL abort_busy: busy=%b/%b ready=%b want 1 1 0", if0.busy, if1.busy, if0.prog_ready); end
      prog_valid = 1'b0; prog_last = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0; done_seen = 1'b0;
      while (if0.busy && n < 200) begin
         prog_start = (n == 5);
         tick();
         n++;
         if (if0.prog_done || if1.prog_done) done_seen = 1'b1;
      end
      prog_start = 1'b0;
      tests++; if (n !== 64) begin fails++; $display("FAIL abort_clear_cycles: got %0d want 64", n); end
      tests++; if (done_seen !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b want 0", done_seen); end
      tick();
      tests++; if (if0.prog_ready !== 1'b0 || if0.busy !== 1'b0) begin fails++; $display("FAIL clear_start_ignored: ready=%b busy=%b want 0 0", if0.prog_ready, if0.busy); end
      pc = 32'd0; #1;
      tests++; if (if0.instruction !== 32'h0 || if0.instr_valid !== 1'b1) begin fails++; $display("FAIL abort_pc0: got %h v=%b want 00000000 v=1", if0.instruction, if0.instr_valid); end
      pc = 32'd4; #1;
      tests++; if (if0.instruction !== 32'h0) begin fails++; $display("FAIL abort_pc4: got %h want 00000000", if0.instruction); end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_overrun();
      test_faults();
      test_gapped();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
